fetch_queue: RTL

Instruction-fetch stage that sits directly downstream of the program counter and upstream of decode. Each cycle it decides whether the current PC may be issued to instruction memory, and drives the PC's `Enable` to advance it only when a fetch is accepted or a redirect occurs. Responses land in an in-order queue that pairs each instruction with its PC and presents them to decode through a valid/ready handshake. On a taken branch or jump, in-flight fetches are squashed so that no wrong-path instruction reaches decode.

---
 rtl/fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC register and decode.
// Issues the current PC to instruction memory when a queue slot is free, advances the PC
// only on an accepted fetch or a redirect, and returns responses to decode in order,
// paired with their PC. A Flush squashes every queued entry, and responses still due
// from squashed fetches are discarded when they arrive.
// Build option: define FETCH_BYPASS_EN to forward a response straight to decode in the
// cycle it fills the head entry (1-cycle best-case latency instead of 2).
module fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_in,
  output logic        pc_enable,
  input  logic        Flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PtrW-1:0] alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CntW-1:0] alloc_cnt_q, unfilled_cnt_q, drop_cnt_q;

  logic            fire, pop, resp_fill, resp_drop, head_ready, bypass, fill_write;
  logic [CntW-1:0] pending_cnt, flush_drop;

  // Decode this cycle's events and drive the combinational outputs
  always_comb begin
    resp_drop  = imem_resp_valid & (drop_cnt_q != '0);
    // A response with nothing unfilled is a protocol error and is ignored
    resp_fill  = imem_resp_valid & (drop_cnt_q == '0) & (unfilled_cnt_q != '0);
    head_ready = filled_q[head_ptr_q] & (alloc_cnt_q != '0);
`ifdef FETCH_BYPASS_EN
    // fill == head with something unfilled means the head itself is being filled now
    bypass     = resp_fill & (fill_ptr_q == head_ptr_q);
`else
    bypass     = 1'b0;
`endif
    id_valid   = !Reset & !Flush & (head_ready | bypass);
    pop        = id_valid & id_ready;
    // A slot freed by decode this cycle can be reused at once, so a full queue keeps
    // streaming one instruction per cycle
    imem_req_valid = !Reset & !Flush & (drop_cnt_q == '0) & ((alloc_cnt_q < DepthCnt) | pop);
    fire          = imem_req_valid & imem_req_ready;
    pc_enable     = !Reset & (fire | Flush);
    imem_req_addr = pc_in;

    if (id_valid) begin
      id_pc    = pc_q[head_ptr_q];
      id_instr = head_ready ? instr_q[head_ptr_q] : imem_resp_data;
    end else begin
      id_pc    = 32'h0;
      id_instr = Nop;
    end

    // An entry popped in the same cycle it is filled is simply freed
    fill_write = resp_fill & !(bypass & pop);

    // Squashed responses still due: earlier drops plus every unfilled entry, less one
    // for a response landing in the flush cycle (it is discarded too)
    pending_cnt = drop_cnt_q + unfilled_cnt_q;
    flush_drop  = (imem_resp_valid && (pending_cnt != '0)) ? pending_cnt - CntW'(1) : pending_cnt;
  end

  // Queue state: Reset wins over Flush, Flush wins over fetch, fill and pop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      alloc_ptr_q    <= '0;
      fill_ptr_q     <= '0;
      head_ptr_q     <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      drop_cnt_q     <= '0;
      filled_q       <= '0;
    end else if (Flush) begin
      alloc_ptr_q    <= '0;
      fill_ptr_q     <= '0;
      head_ptr_q     <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      drop_cnt_q     <= flush_drop;
      filled_q       <= '0;
    end else begin
      if (fire) begin
        pc_q[alloc_ptr_q]     <= pc_in;
        filled_q[alloc_ptr_q] <= 1'b0;
        alloc_ptr_q           <= alloc_ptr_q + PtrW'(1);
      end
      if (resp_drop) begin
        drop_cnt_q <= drop_cnt_q - CntW'(1);
      end
      if (resp_fill) begin
        fill_ptr_q <= fill_ptr_q + PtrW'(1);
      end
      if (fill_write) begin
        instr_q[fill_ptr_q]  <= imem_resp_data;
        filled_q[fill_ptr_q] <= 1'b1;
      end
      if (pop) begin
        filled_q[head_ptr_q] <= 1'b0;
        head_ptr_q           <= head_ptr_q + PtrW'(1);
      end
      alloc_cnt_q    <= alloc_cnt_q + CntW'(fire) - CntW'(pop);
      unfilled_cnt_q <= unfilled_cnt_q + CntW'(fire) - CntW'(resp_fill);
    end
  end

endmodule
